signal_phase_ctrl: RTL
======================

Name: signal_phase_ctrl

Overview:
- Downstream consumer of the lane-count comparator flags (m_more, l_zero, s_more, p_more, absolute_num).
- Sequences the intersection through its light phases.
- Stretches or skips phases based on the demand flags sampled at each phase entry.
- Drives the main, left-turn, secondary and pedestrian signal heads.
- Counts time in whole ticks from the shared 1 Hz tick enable.

Parameters:
- MAIN_BASE, 8: base main-green duration in ticks
- LEFT_BASE, 4: base left-arrow duration in ticks
- SEC_BASE, 6: base secondary-green duration in ticks
- YEL_TIME, 3: yellow duration for main and secondary
- RED_TIME, 1: all-red clearance duration
- PED_TIME, 5: pedestrian walk duration
- EXT_STEP, 2: ticks added per unit of absolute_num, and the fixed secondary extension
- CNT_W, 6: width of the phase countdown

Ports:
- clk, in, 1: system clock
- rst_n, in, 1: asynchronous active-low reset
- tick, in, 1: one-cycle enable, once per second
- m_more, in, 1: main count > left count
- l_zero, in, 1: left-turn count is zero
- s_more, in, 1: secondary count > main count
- p_more, in, 1: pedestrian count > secondary count
- absolute_num, in, 3: |main - left|
- main_light, out, 3: main head, one-hot {red,yellow,green}
- left_arrow, out, 1: main left-turn arrow on
- sec_light, out, 3: secondary head, one-hot {red,yellow,green}
- ped_walk, out, 1: pedestrian walk lamp
- phase, out, 3: current state encoding
- remain, out, CNT_W: ticks left in current phase

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Fixed for this block.
- State encodings: MAIN_G=0, LEFT_G=1, MAIN_Y=2, RED_A=3, SEC_G=4, SEC_Y=5, RED_B=6, PED=7.
- Reset values:
  - phase=RED_B, remain=RED_TIME, ped_req=0
  - main_light=100, sec_light=100, left_arrow=0, ped_walk=0
- Countdown:
  - On a tick with remain>1: remain decrements.
  - On a tick with remain==1: the state advances and remain loads the next state's duration on the same edge.
  - With no tick, state and remain hold.
  - Each phase therefore lasts exactly its duration in ticks.
- Transitions:
  - MAIN_G -> LEFT_G if l_zero==0, else -> MAIN_Y
  - LEFT_G -> MAIN_Y
  - MAIN_Y -> RED_A -> SEC_G -> SEC_Y -> RED_B
  - RED_B -> PED if ped_req, else -> MAIN_G
  - PED -> MAIN_G
- Flag sampling: l_zero is sampled on the edge that leaves MAIN_G.
- Durations are computed from the flags on the loading edge:
  - MAIN_G = MAIN_BASE + (m_more ? absolute_num*EXT_STEP : 0)
  - LEFT_G = LEFT_BASE + (m_more ? 0 : absolute_num*EXT_STEP)
  - SEC_G = SEC_BASE + (s_more ? EXT_STEP : 0)
  - MAIN_Y, SEC_Y = YEL_TIME; RED_A, RED_B = RED_TIME; PED = PED_TIME
- Duration arithmetic:
  - Computed at CNT_W+4 bits, then saturated to 2^CNT_W-1.
  - A computed duration of 0 loads 1.
- ped_req:
  - Set on any cycle in SEC_G, SEC_Y or RED_B with p_more=1.
  - Cleared on the edge entering PED.
  - Held otherwise.
  - A request arriving in RED_B on the exiting edge counts.
- Output decode:
  - Outputs are a combinational decode of the registered state, so they change in the cycle after the transition edge.
  - main_light green in MAIN_G/LEFT_G, yellow in MAIN_Y, otherwise red.
  - left_arrow=1 only in LEFT_G.
  - sec_light green in SEC_G, yellow in SEC_Y, otherwise red.
  - ped_walk=1 only in PED.
  - Main and secondary heads are never both non-red.
- Reset mid-phase returns to the reset values immediately, regardless of tick.
- Illegal phase values are unreachable; the default branch goes to RED_B with remain=RED_TIME.

Test Plan:
- Reset, then 1 tick:
  - During reset: phase=6, remain=1, both heads 100.
  - After the tick: phase=0.
  - With m_more=0 at entry, remain=8.
- Main extension:
  - Stimulus: m_more=1, absolute_num=3 at MAIN_G entry.
  - Response: remain=14, MAIN_G lasts exactly 14 ticks, 8 non-tick cycles between ticks leave remain unchanged.
- Left skip vs. serve:
  - l_zero=1 at MAIN_G exit -> next phase=2.
  - l_zero=0, m_more=0, absolute_num=2 -> phase=1 with remain=8 and left_arrow=1.
- Pedestrian service:
  - p_more pulses 1 cycle during SEC_G -> after RED_B, phase=7 and ped_walk=1 for 5 ticks, then phase=0.
  - With no pulse: RED_B -> phase=0.
- Saturation:
  - Stimulus: MAIN_BASE=60, m_more=1, absolute_num=7.
  - Response: remain loads 63, not 74.
- Mid-phase reset:
  - Stimulus: assert rst_n=0 in SEC_G with remain=3, between clock edges.
  - Response: outputs return to reset values immediately; after release, the sequence restarts from RED_B.

Source files
------------

// File: rtl/signal_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : signal_phase_ctrl
//  Description : Intersection light sequencer. Steps through the main green,
//                left arrow, yellows, all-red clearances, secondary green and
//                pedestrian walk phases. Each phase length is counted in whole
//                ticks. Green lengths stretch with the comparator demand flags
//                sampled when the phase is loaded.
//  Ports       : clk, rst_n          - clock, asynchronous active-low reset
//                tick                - one-cycle enable, once per second
//                m_more, l_zero, s_more, p_more, absolute_num
//                                    - lane-count comparator flags
//                main_light/sec_light- one-hot {red,yellow,green} heads
//                left_arrow,ped_walk - main left arrow, pedestrian walk lamp
//                phase, remain       - current state, ticks left in phase
//  Revision    : 1.0 - initial release
// ============================================================================
module signal_phase_ctrl #(
    parameter int MAIN_BASE = 8,
    parameter int LEFT_BASE = 4,
    parameter int SEC_BASE  = 6,
    parameter int YEL_TIME  = 3,
    parameter int RED_TIME  = 1,
    parameter int PED_TIME  = 5,
    parameter int EXT_STEP  = 2,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             m_more,
    input  logic             l_zero,
    input  logic             s_more,
    input  logic             p_more,
    input  logic [2:0]       absolute_num,
    output logic [2:0]       main_light,
    output logic             left_arrow,
    output logic [2:0]       sec_light,
    output logic             ped_walk,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remain
);

    // Durations are formed four bits wider than the countdown so that the
    // largest base plus extension cannot wrap before it is saturated.
    localparam int               DUR_W   = CNT_W + 4;
    localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'((1 << CNT_W) - 1);

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        LEFT_G = 3'd1,
        MAIN_Y = 3'd2,
        RED_A  = 3'd3,
        SEC_G  = 3'd4,
        SEC_Y  = 3'd5,
        RED_B  = 3'd6,
        PED    = 3'd7
    } phase_t;

    phase_t           state;
    phase_t           state_nxt;
    phase_t           adv_state;
    logic [CNT_W-1:0] remain_nxt;
    logic [CNT_W-1:0] load_dur;
    logic             ped_req;
    logic             ped_req_nxt;
    logic             ped_seen;

    logic [DUR_W-1:0] ext;
    logic [DUR_W-1:0] main_raw;
    logic [DUR_W-1:0] left_raw;
    logic [DUR_W-1:0] sec_raw;
    logic [CNT_W-1:0] red_load;

    // Saturate to the countdown range; a zero length would stall the phase,
    // so it is promoted to a single tick.
    function automatic logic [CNT_W-1:0] clamp_dur(input logic [DUR_W-1:0] raw);
        logic [CNT_W-1:0] res;
        if (raw == '0) begin
            res = CNT_W'(1);
        end else if (raw > DUR_MAX) begin
            res = DUR_MAX[CNT_W-1:0];
        end else begin
            res = raw[CNT_W-1:0];
        end
        return res;
    endfunction

    assign ext      = DUR_W'(absolute_num) * DUR_W'(EXT_STEP);
    assign main_raw = DUR_W'(MAIN_BASE) + (m_more ? ext : '0);
    assign left_raw = DUR_W'(LEFT_BASE) + (m_more ? '0 : ext);
    assign sec_raw  = DUR_W'(SEC_BASE) + (s_more ? DUR_W'(EXT_STEP) : '0);
    assign red_load = clamp_dur(DUR_W'(RED_TIME));

    // Successor phase and its length, evaluated every cycle but only used on
    // the tick that expires the current phase.
    always_comb begin
        adv_state = RED_B;
        // A request raised on the very edge that leaves RED_B still counts.
        ped_seen  = ped_req |
                    (p_more & ((state == SEC_G) || (state == SEC_Y) || (state == RED_B)));
        case (state)
            MAIN_G:  adv_state = l_zero ? MAIN_Y : LEFT_G;
            LEFT_G:  adv_state = MAIN_Y;
            MAIN_Y:  adv_state = RED_A;
            RED_A:   adv_state = SEC_G;
            SEC_G:   adv_state = SEC_Y;
            SEC_Y:   adv_state = RED_B;
            RED_B:   adv_state = ped_seen ? PED : MAIN_G;
            PED:     adv_state = MAIN_G;
            default: adv_state = RED_B;
        endcase
    end

    always_comb begin
        load_dur = red_load;
        case (adv_state)
            MAIN_G:  load_dur = clamp_dur(main_raw);
            LEFT_G:  load_dur = clamp_dur(left_raw);
            MAIN_Y:  load_dur = clamp_dur(DUR_W'(YEL_TIME));
            RED_A:   load_dur = red_load;
            SEC_G:   load_dur = clamp_dur(sec_raw);
            SEC_Y:   load_dur = clamp_dur(DUR_W'(YEL_TIME));
            RED_B:   load_dur = red_load;
            PED:     load_dur = clamp_dur(DUR_W'(PED_TIME));
            default: load_dur = red_load;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        remain_nxt  = remain;
        ped_req_nxt = ped_seen;
        if (tick) begin
            if (remain > CNT_W'(1)) begin
                remain_nxt = remain - CNT_W'(1);
            end else begin
                state_nxt  = adv_state;
                remain_nxt = load_dur;
                if (adv_state == PED) begin
                    ped_req_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RED_B;
            remain  <= red_load;
            ped_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            remain  <= remain_nxt;
            ped_req <= ped_req_nxt;
        end
    end

    // Heads decode the registered phase only, so the two directions can never
    // show non-red together.
    always_comb begin
        main_light = LIGHT_RED;
        sec_light  = LIGHT_RED;
        left_arrow = 1'b0;
        ped_walk   = 1'b0;
        case (state)
            MAIN_G:  main_light = LIGHT_GRN;
            LEFT_G:  begin
                main_light = LIGHT_GRN;
                left_arrow = 1'b1;
            end
            MAIN_Y:  main_light = LIGHT_YEL;
            SEC_G:   sec_light  = LIGHT_GRN;
            SEC_Y:   sec_light  = LIGHT_YEL;
            PED:     ped_walk   = 1'b1;
            default: ;
        endcase
    end

    assign phase = state;

endmodule
`default_nettype wire
